// File: rtl/axioma_spm_pkg.sv
// Shared definitions for the SPM sequencer: SPMCSR layout, FSM encoding and defaults.
package axioma_spm_pkg;

  localparam int unsigned SPMCSR_W       = 8;
  localparam int unsigned SPMIE_BIT      = 7;
  localparam int unsigned RWWSB_BIT      = 6;
  localparam int unsigned RSVD5_BIT      = 5;
  localparam int unsigned RWWSRE_BIT     = 4;
  localparam int unsigned RSVD3_BIT      = 3;
  localparam int unsigned PGWRT_BIT      = 2;
  localparam int unsigned PGERS_BIT      = 1;
  localparam int unsigned SPMEN_BIT      = 0;
  localparam int unsigned ARM_WINDOW_DEF = 4;
  localparam int unsigned Z_PAGE_LSB     = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_ERASE_REQ = 3'd3,
    ST_WRITE_REQ = 3'd4,
    ST_WAIT      = 3'd5,
    ST_DONE      = 3'd6
  } spm_state_e;

  typedef struct packed {
    logic spmie;
    logic rwwsb;
    logic rsvd5;
    logic rwwsre;
    logic rsvd3;
    logic pgwrt;
    logic pgers;
    logic spmen;
  } spmcsr_t;

  // Drops the one-shot command bits once an operation or arming window ends.
  function automatic spmcsr_t clear_op_bits(input spmcsr_t c);
    spmcsr_t r;
    r        = c;
    r.spmen  = 1'b0;
    r.pgers  = 1'b0;
    r.pgwrt  = 1'b0;
    r.rwwsre = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/axioma_spm_ctrl.sv
// SPM sequencer: owns SPMCSR, arms on SPMEN, and turns the core's SPM strobe
// into buffer-load / erase / page-write pulses toward the flash controller.
module axioma_spm_ctrl
  import axioma_spm_pkg::*;
#(
  parameter int unsigned ARM_WINDOW     = ARM_WINDOW_DEF,
  parameter int unsigned BUSY_RISE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned PAGE_BITS      = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spmcsr_wr,
  input  logic [SPMCSR_W-1:0]   spmcsr_wdata,
  output logic [SPMCSR_W-1:0]   spmcsr_rdata,
  input  logic                  spm_exec,
  input  logic [15:0]           spm_z,
  input  logic [15:0]           spm_r1r0,
  output logic                  cpu_stall,
  output logic                  fl_buf_load,
  output logic [15:0]           fl_buf_data,
  output logic [PAGE_BITS-1:0]  fl_page_addr,
  output logic                  fl_erase,
  output logic                  fl_page_write,
  input  logic                  fl_busy,
  output logic                  spm_irq,
  output logic                  spm_error
);

  localparam int unsigned ARM_W  = $clog2(ARM_WINDOW + 1);
  localparam int unsigned RISE_W = $clog2(BUSY_RISE_MAX + 1);
  localparam int unsigned TMO_W  = 8;

  spm_state_e            state_q, state_d;
  spmcsr_t               csr_q, csr_d;
  logic [ARM_W-1:0]      arm_cnt_q, arm_cnt_d;
  logic [RISE_W-1:0]     rise_cnt_q, rise_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  busy_seen_q, busy_seen_d;
  logic [PAGE_BITS-1:0]  page_d;
  logic [15:0]           data_d;
  logic                  err_d;
  logic                  buf_load_d, erase_d, page_write_d, stall_d;
  logic                  multi_op;

  // Upper Z bits, in-page offset and read-only/reserved write bits carry no state here.
  logic unused_inputs;
  assign unused_inputs = ^{spm_z[15:Z_PAGE_LSB+PAGE_BITS], spm_z[Z_PAGE_LSB-1:0],
                           spmcsr_wdata[RWWSB_BIT], spmcsr_wdata[RSVD5_BIT],
                           spmcsr_wdata[RSVD3_BIT]};

  assign multi_op     = (csr_q.pgers & csr_q.pgwrt) | (csr_q.pgers & csr_q.rwwsre) |
                        (csr_q.pgwrt & csr_q.rwwsre);
  assign spmcsr_rdata = csr_q;
  assign spm_irq      = csr_q.spmie & ~csr_q.spmen;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      csr_q         <= '0;
      arm_cnt_q     <= '0;
      rise_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      busy_seen_q   <= 1'b0;
      fl_page_addr  <= '0;
      fl_buf_data   <= '0;
      spm_error     <= 1'b0;
      fl_buf_load   <= 1'b0;
      fl_erase      <= 1'b0;
      fl_page_write <= 1'b0;
      cpu_stall     <= 1'b0;
    end else begin
      state_q       <= state_d;
      csr_q         <= csr_d;
      arm_cnt_q     <= arm_cnt_d;
      rise_cnt_q    <= rise_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      busy_seen_q   <= busy_seen_d;
      fl_page_addr  <= page_d;
      fl_buf_data   <= data_d;
      spm_error     <= err_d;
      fl_buf_load   <= buf_load_d;
      fl_erase      <= erase_d;
      fl_page_write <= page_write_d;
      cpu_stall     <= stall_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin : next_state_comb
    state_d     = state_q;
    csr_d       = csr_q;
    arm_cnt_d   = arm_cnt_q;
    rise_cnt_d  = rise_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    busy_seen_d = busy_seen_q;
    page_d      = fl_page_addr;
    data_d      = fl_buf_data;
    err_d       = spm_error;

    if (spmcsr_wr) csr_d.spmie = spmcsr_wdata[SPMIE_BIT];

    case (state_q)
      ST_IDLE: begin
        if (spmcsr_wr && spmcsr_wdata[SPMEN_BIT]) begin
          csr_d.rwwsre = spmcsr_wdata[RWWSRE_BIT];
          csr_d.pgwrt  = spmcsr_wdata[PGWRT_BIT];
          csr_d.pgers  = spmcsr_wdata[PGERS_BIT];
          csr_d.spmen  = 1'b1;
          arm_cnt_d    = ARM_W'(ARM_WINDOW);
          err_d        = 1'b0;
          state_d      = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (arm_cnt_q == '0) begin
          csr_d   = clear_op_bits(csr_d);
          state_d = ST_IDLE;
        end else if (spm_exec) begin
          // A simultaneous SPMCSR write loses to the executing SPM.
          csr_d.spmie = csr_q.spmie;
          arm_cnt_d   = '0;
          page_d      = spm_z[Z_PAGE_LSB +: PAGE_BITS];
          data_d      = spm_r1r0;
          rise_cnt_d  = '0;
          tmo_cnt_d   = '0;
          busy_seen_d = 1'b0;
          if (multi_op) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (csr_q.pgers) begin
            csr_d.rwwsb = 1'b1;
            state_d     = ST_ERASE_REQ;
          end else if (csr_q.pgwrt) begin
            csr_d.rwwsb = 1'b1;
            state_d     = ST_WRITE_REQ;
          end else if (csr_q.rwwsre) begin
            if (fl_busy) err_d       = 1'b1;
            else         csr_d.rwwsb = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          arm_cnt_d = arm_cnt_q - ARM_W'(1);
        end
      end
      ST_LOAD:      state_d = ST_DONE;
      ST_ERASE_REQ: state_d = ST_WAIT;
      ST_WRITE_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        // Busy must rise within the rise window, then fall before the timeout.
        if (fl_busy) begin
          busy_seen_d = 1'b1;
          if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end else if (busy_seen_q) begin
          state_d = ST_DONE;
        end else if (rise_cnt_q == RISE_W'(BUSY_RISE_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          rise_cnt_d = rise_cnt_q + RISE_W'(1);
        end
      end
      ST_DONE: begin
        csr_d   = clear_op_bits(csr_d);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulse and stall outputs follow the state being entered.
  always_comb begin : output_comb
    buf_load_d   = 1'b0;
    erase_d      = 1'b0;
    page_write_d = 1'b0;
    stall_d      = 1'b0;
    buf_load_d   = (state_d == ST_LOAD);
    erase_d      = (state_d == ST_ERASE_REQ);
    page_write_d = (state_d == ST_WRITE_REQ);
    stall_d      = (state_d == ST_ERASE_REQ) || (state_d == ST_WRITE_REQ) ||
                   (state_d == ST_WAIT) || ((state_d == ST_DONE) && (state_q == ST_WAIT));
  end

endmodule

// File: tb/tb_axioma_spm_ctrl.sv
// Directed bench for axioma_spm_ctrl: flash pulses are checked against a scoreboard
// queue filled at spm_exec time; register and status values are checked inline.
module tb_axioma_spm_ctrl;

  localparam int unsigned PAGE_BITS = 6;
  localparam logic [2:0]  K_LOAD    = 3'b001;
  localparam logic [2:0]  K_ERASE   = 3'b010;
  localparam logic [2:0]  K_WRITE   = 3'b100;

  typedef struct packed {
    logic [2:0]           kind;
    logic [PAGE_BITS-1:0] page;
    logic [15:0]          data;
  } ev_t;

  logic                 clk          = 1'b0;
  logic                 reset_n      = 1'b0;
  logic                 spmcsr_wr    = 1'b0;
  logic [7:0]           spmcsr_wdata = 8'h00;
  logic [7:0]           spmcsr_rdata;
  logic                 spm_exec     = 1'b0;
  logic [15:0]          spm_z        = 16'h0000;
  logic [15:0]          spm_r1r0     = 16'h0000;
  logic                 cpu_stall;
  logic                 fl_buf_load;
  logic [15:0]          fl_buf_data;
  logic [PAGE_BITS-1:0] fl_page_addr;
  logic                 fl_erase;
  logic                 fl_page_write;
  logic                 fl_busy      = 1'b0;
  logic                 spm_irq;
  logic                 spm_error;

  int  n_cmp        = 0;
  int  n_bad        = 0;
  int  stall_cycles = 0;
  int  n_pulses     = 0;
  int  pulses_mark  = 0;
  ev_t exp_q[$];

  axioma_spm_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spmcsr_wr    (spmcsr_wr),
    .spmcsr_wdata (spmcsr_wdata),
    .spmcsr_rdata (spmcsr_rdata),
    .spm_exec     (spm_exec),
    .spm_z        (spm_z),
    .spm_r1r0     (spm_r1r0),
    .cpu_stall    (cpu_stall),
    .fl_buf_load  (fl_buf_load),
    .fl_buf_data  (fl_buf_data),
    .fl_page_addr (fl_page_addr),
    .fl_erase     (fl_erase),
    .fl_page_write(fl_page_write),
    .fl_busy      (fl_busy),
    .spm_irq      (spm_irq),
    .spm_error    (spm_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PAGE_BITS-1:0] page_of(input logic [15:0] z);
    return z[PAGE_BITS+6:7];
  endfunction

  // One clock; sample 1 time unit after the edge and score any flash pulse.
  task automatic tick();
    ev_t obs;
    ev_t e;
    @(posedge clk);
    #1;
    if (cpu_stall) stall_cycles++;
    if (fl_buf_load || fl_erase || fl_page_write) begin
      n_pulses++;
      obs.kind = {fl_page_write, fl_erase, fl_buf_load};
      obs.page = fl_page_addr;
      obs.data = fl_buf_load ? fl_buf_data : 16'h0000;
      check("pulse_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pulse_event", 64'(obs), 64'(e));
      end
    end
  endtask

  task automatic csr_write(input logic [7:0] d);
    spmcsr_wr    = 1'b1;
    spmcsr_wdata = d;
    tick();
    spmcsr_wr    = 1'b0;
    spmcsr_wdata = 8'h00;
  endtask

  task automatic do_exec(input logic [15:0] z, input logic [15:0] r, input bit expect_ev,
                         input logic [2:0] kind);
    ev_t e;
    if (expect_ev) begin
      e.kind = kind;
      e.page = page_of(z);
      e.data = (kind == K_LOAD) ? r : 16'h0000;
      exp_q.push_back(e);
    end
    spm_exec = 1'b1;
    spm_z    = z;
    spm_r1r0 = r;
    tick();
    spm_exec = 1'b0;
  endtask

  task automatic wait_stall_low(input int bound, input string tag);
    int i;
    i = 0;
    while (cpu_stall && i < bound) begin
      tick();
      i++;
    end
    check(tag, 64'(cpu_stall), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, 64'({cpu_stall, fl_buf_load, fl_erase, fl_page_write, spm_irq, spm_error,
                    fl_page_addr, fl_buf_data, spmcsr_rdata}), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    reset_n = 1'b1;
    tick();

    // Buffer load two cycles after arming.
    csr_write(8'h01);
    tick();
    stall_cycles = 0;
    do_exec(16'h0040, 16'hA55A, 1'b1, K_LOAD);
    repeat (3) tick();
    check("t1_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t1_spmcsr", 64'(spmcsr_rdata), 64'h00);
    check("t1_no_stall", 64'(stall_cycles), 64'd0);

    // Arming window expires; a late SPM does nothing.
    csr_write(8'h01);
    repeat (3) tick();
    check("t2_still_armed", 64'(spmcsr_rdata), 64'h01);
    repeat (2) tick();
    check("t2_expired", 64'(spmcsr_rdata), 64'h00);
    pulses_mark = n_pulses;
    do_exec(16'h0080, 16'h1234, 1'b0, K_LOAD);
    repeat (3) tick();
    check("t2_late_exec_no_pulse", 64'(n_pulses), 64'(pulses_mark));

    // SPM on the last armed cycle is still accepted.
    csr_write(8'h01);
    repeat (3) tick();
    do_exec(16'h0100, 16'hBEEF, 1'b1, K_LOAD);
    repeat (3) tick();
    check("t2b_last_cycle_exec", 64'(exp_q.size()), 64'd0);

    // Page erase, busy held for 16 cycles: 1 request + 16 busy + 1 done stalled.
    csr_write(8'h03);
    stall_cycles = 0;
    do_exec(16'h0380, 16'h0000, 1'b1, K_ERASE);
    fl_busy = 1'b1;
    repeat (16) tick();
    fl_busy = 1'b0;
    wait_stall_low(20, "t3_stall_release");
    check("t3_stall_cycles", 64'(stall_cycles), 64'd18);
    check("t3_rwwsb_set", 64'(spmcsr_rdata), 64'h40);
    check("t3_no_error", 64'(spm_error), 64'd0);
    csr_write(8'h11);
    stall_cycles = 0;
    do_exec(16'h0000, 16'h0000, 1'b0, K_LOAD);
    repeat (3) tick();
    check("t3_rww_reenabled", 64'(spmcsr_rdata), 64'h00);
    check("t3_rwwsre_no_stall", 64'(stall_cycles), 64'd0);

    // Page write with busy stuck high: timeout abort near 255 busy cycles.
    csr_write(8'h85);
    stall_cycles = 0;
    do_exec(16'h1F80, 16'h5555, 1'b1, K_WRITE);
    fl_busy = 1'b1;
    wait_stall_low(400, "t4_stall_release");
    fl_busy = 1'b0;
    check("t4_abort_window", 64'(stall_cycles >= 255 && stall_cycles <= 260), 64'd1);
    check("t4_error", 64'(spm_error), 64'd1);
    check("t4_irq", 64'(spm_irq), 64'd1);
    check("t4_spmcsr", 64'(spmcsr_rdata), 64'hC0);

    // Conflicting command bits: error, no pulse; re-arming clears the error.
    csr_write(8'h07);
    check("t5_arm_clears_error", 64'(spm_error), 64'd0);
    pulses_mark  = n_pulses;
    stall_cycles = 0;
    do_exec(16'h0000, 16'h0000, 1'b0, K_LOAD);
    repeat (2) tick();
    check("t5_error", 64'(spm_error), 64'd1);
    check("t5_no_pulse", 64'(n_pulses), 64'(pulses_mark));
    check("t5_spmcsr", 64'(spmcsr_rdata), 64'h40);
    csr_write(8'h01);
    check("t5_rearm_clears_error", 64'(spm_error), 64'd0);
    repeat (6) tick();

    // SPMCSR write in the same cycle as SPM is dropped.
    csr_write(8'h01);
    spmcsr_wr    = 1'b1;
    spmcsr_wdata = 8'h80;
    do_exec(16'h0200, 16'h0F0F, 1'b1, K_LOAD);
    spmcsr_wr    = 1'b0;
    spmcsr_wdata = 8'h00;
    repeat (3) tick();
    check("t5b_write_dropped", 64'(spmcsr_rdata), 64'h40);

    // Reset while waiting on the flash.
    csr_write(8'h03);
    do_exec(16'h0100, 16'h0000, 1'b1, K_ERASE);
    fl_busy = 1'b1;
    repeat (4) tick();
    check("t6_stalled", 64'(cpu_stall), 64'd1);
    check("t6_spmcsr_before", 64'(spmcsr_rdata), 64'h43);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_reset_mid_wait");
    #2;
    reset_n = 1'b1;
    fl_busy = 1'b0;
    tick();
    check_outputs_zero("t6_after_release");

    check("final_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
